// File: rtl/vga_pkg.sv
// Shared VGA frame geometry for the frame-buffer scan-out path.
// No logic: constants and small types only.
// Imported by vga_fb_reader and its bench.
package vga_pkg;

    localparam int H_ACTIVE     = 640;
    localparam int V_ACTIVE     = 480;
    localparam int PIX_PER_WORD = 4;
    localparam int FB_PIXELS    = H_ACTIVE * V_ACTIVE;
    localparam int FB_WORDS     = FB_PIXELS / PIX_PER_WORD;
    localparam int PIX_CNT_W    = $clog2(FB_PIXELS);

    // Byte lane within a frame-buffer word, lane 0 = bits 7:0.
    typedef logic [1:0] lane_t;

endpackage

// File: rtl/vga_sync_fifo.sv
// Generic synchronous FIFO with flush; head word visible combinationally on pop_data.
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: pushes while full are dropped unless a pop happens in the same cycle; pops while empty are ignored.
// Ports: push/push_data write, pop advances head, flush empties (wins over push/pop), count/full/empty status.
module vga_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop & ~flush & ~empty;
    // A full FIFO can still accept a word when the head leaves in the same cycle.
    assign do_push  = push & ~flush & (~full | do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/vga_fb_reader.sv
// Frame-buffer reader: prefetches 4-pixel words from memory and serialises them into 8-bit pixels.
// Latency: pix_data/pix_valid registered one cycle after pix_req; memory data returns one cycle after mem_addr_out.
// Backpressure: reads issue only while FIFO count plus in-flight read leaves room; pix_req on empty FIFO flags sticky underflow.
// Ports: clk/resetn; enable, frame_start, pix_req from timing; mem_addr_out/mem_data_in to memory;
//        pix_data/pix_valid/frame_done/underflow to the display pipeline.
module vga_fb_reader
    import vga_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  enable,
    input  logic                  frame_start,
    input  logic                  pix_req,
    output logic [ADDR_WIDTH-1:0] mem_addr_out,
    input  logic [DATA_WIDTH-1:0] mem_data_in,
    output logic [7:0]            pix_data,
    output logic                  pix_valid,
    output logic                  frame_done,
    output logic                  underflow
);

    localparam int CW = $clog2(FIFO_DEPTH);

    logic                  flush;
    logic                  issue;
    logic                  take;
    logic                  starve;
    logic                  pop_word;
    logic                  push_word;
    logic [CW:0]           fifo_count;
    logic [CW:0]           occupancy;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] head;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  inflight;
    lane_t                 lane;
    logic [PIX_CNT_W-1:0]  pix_cnt;

    // Leaving the active state (disable) or a new frame both restart scan-out from word 0.
    assign flush     = frame_start | ~enable;

    // Count the in-flight read as occupied so the returning word always has a slot.
    assign occupancy = fifo_count + {{CW{1'b0}}, inflight};
    assign issue     = enable & ~frame_start & ~fifo_full & (occupancy < (CW+1)'(FIFO_DEPTH));

    assign take      = pix_req & ~flush & ~fifo_empty;
    assign starve    = pix_req & ~flush & fifo_empty;
    assign pop_word  = take & (lane == 2'd3);
    // A read issued before a flush returns stale data; drop it.
    assign push_word = inflight & ~flush;

    assign mem_addr_out = rd_addr;

    vga_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push_word),
        .push_data (mem_data_in),
        .pop       (pop_word),
        .flush     (flush),
        .pop_data  (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_addr    <= '0;
            inflight   <= 1'b0;
            lane       <= '0;
            pix_cnt    <= '0;
            pix_data   <= '0;
            pix_valid  <= 1'b0;
            frame_done <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            inflight   <= issue;
            pix_valid  <= take;
            pix_data   <= take ? head[{lane, 3'b000} +: 8] : 8'h00;
            frame_done <= take & (pix_cnt == PIX_CNT_W'(FB_PIXELS - 1));

            if (flush) begin
                rd_addr <= '0;
                lane    <= '0;
                pix_cnt <= '0;
            end else begin
                if (issue) begin
                    rd_addr <= (rd_addr == ADDR_WIDTH'(FB_WORDS - 1)) ? '0 : rd_addr + ADDR_WIDTH'(1);
                end
                if (take) begin
                    lane    <= lane + 2'd1;
                    pix_cnt <= (pix_cnt == PIX_CNT_W'(FB_PIXELS - 1)) ? '0 : pix_cnt + PIX_CNT_W'(1);
                end
            end

            // Only a new frame clears the sticky flag; disabling scan-out keeps it for inspection.
            if (frame_start) begin
                underflow <= 1'b0;
            end else if (starve) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_fb_reader.sv
module tb_vga_fb_reader;
    import vga_pkg::*;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic          enable;
    logic          frame_start;
    logic          pix_req;
    logic [AW-1:0] mem_addr_out;
    logic [DW-1:0] mem_data_in;
    logic [7:0]    pix_data;
    logic          pix_valid;
    logic          frame_done;
    logic          underflow;

    always #5 clk = ~clk;

    vga_fb_reader #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .enable       (enable),
        .frame_start  (frame_start),
        .pix_req      (pix_req),
        .mem_addr_out (mem_addr_out),
        .mem_data_in  (mem_data_in),
        .pix_data     (pix_data),
        .pix_valid    (pix_valid),
        .frame_done   (frame_done),
        .underflow    (underflow)
    );

    // Memory contents: mode 0 -> word n = n; mode 1 -> bytes offset from AA/BB/CC/DD (word 0 = 0xDDCCBBAA).
    int mem_mode = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [7:0] b;
        b = a[7:0];
        if (mem_mode == 0) return a;
        return {b + 8'hDD, b + 8'hCC, b + 8'hBB, b + 8'hAA};
    endfunction

    always @(posedge clk) mem_data_in <= mem_word(mem_addr_out);

    typedef struct packed {
        logic       vld;
        logic [7:0] dat;
        logic       done;
    } exp_t;

    exp_t          exp_q[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            pix_idx = 0;
    int            n_done  = 0;
    logic          exp_uf  = 1'b0;
    logic          saw_wrap = 1'b0;
    logic [AW-1:0] prev_addr = '0;

    // One clock: drive inputs, push the expected output, then compare what the DUT registered.
    // kind: 0 = no pixel expected, 1 = next pixel of the stream, 2 = underflow.
    task automatic tick(input logic req, input logic fs, input logic en, input int kind);
        exp_t        e;
        exp_t        got;
        logic [31:0] w;
        e = '0;
        if (fs || !en) begin
            pix_idx = 0;
            if (fs) exp_uf = 1'b0;
        end else if (kind == 1) begin
            w      = mem_word(32'(pix_idx / 4));
            e.vld  = 1'b1;
            e.dat  = w[8*(pix_idx % 4) +: 8];
            e.done = (pix_idx == FB_PIXELS - 1);
            pix_idx = (pix_idx + 1) % FB_PIXELS;
        end else if (kind == 2) begin
            exp_uf = 1'b1;
        end
        exp_q.push_back(e);
        pix_req     = req;
        frame_start = fs;
        enable      = en;
        @(posedge clk);
        @(negedge clk);
        got = {pix_valid, pix_data, frame_done};
        e   = exp_q.pop_front();
        n_tests++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL pixel: got vld=%b dat=%h done=%b, want vld=%b dat=%h done=%b (next idx %0d)",
                     got.vld, got.dat, got.done, e.vld, e.dat, e.done, pix_idx);
        end
        n_tests++;
        if (underflow !== exp_uf) begin
            n_fail++;
            $display("FAIL underflow: got %b, want %b", underflow, exp_uf);
        end
        if (frame_done === 1'b1) n_done++;
        if (prev_addr == AW'(FB_WORDS - 1) && mem_addr_out == '0) saw_wrap = 1'b1;
        prev_addr = mem_addr_out;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b1, 0);
    endtask

    task automatic refill();
        tick(1'b0, 1'b1, 1'b1, 0);
        idle(6);
    endtask

    task automatic test_reset();
        resetn = 1'b0; enable = 1'b1; frame_start = 1'b0; pix_req = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({pix_valid, pix_data, frame_done, underflow} !== 11'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got vld=%b dat=%h done=%b uf=%b, want all 0",
                     pix_valid, pix_data, frame_done, underflow);
        end
        n_tests++;
        if (mem_addr_out !== '0) begin
            n_fail++;
            $display("FAIL reset_addr: got %0d, want 0", mem_addr_out);
        end
        resetn  = 1'b1;
        pix_idx = 0;
        exp_uf  = 1'b0;
    endtask

    task automatic test_underflow();
        tick(1'b1, 1'b0, 1'b1, 2);
        n_tests++;
        if (mem_addr_out !== 32'd1) begin
            n_fail++;
            $display("FAIL first_read: addr got %0d, want 1", mem_addr_out);
        end
        idle(3);
        tick(1'b0, 1'b1, 1'b1, 0);
    endtask

    task automatic test_steady();
        mem_mode = 0;
        refill();
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 1'b1, 1);
    endtask

    task automatic test_lane_order();
        mem_mode = 1;
        refill();
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b1, 1);
    endtask

    task automatic test_back_to_back();
        logic r;
        for (int i = 0; i < 200; i++) begin
            r = 1'($urandom_range(0, 1));
            tick(r, 1'b0, 1'b1, r ? 1 : 0);
        end
    endtask

    task automatic test_enable();
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 0);
        n_tests++;
        if (mem_addr_out !== '0) begin
            n_fail++;
            $display("FAIL disable_addr: got %0d, want 0", mem_addr_out);
        end
        idle(6);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b1, 1);
    endtask

    task automatic test_mid_frame_fs();
        int guard;
        refill();
        guard = 0;
        while (mem_addr_out !== 32'd100 && guard < 2000) begin
            tick(1'b1, 1'b0, 1'b1, 1);
            guard++;
        end
        n_tests++;
        if (mem_addr_out !== 32'd100) begin
            n_fail++;
            $display("FAIL reach_addr100: got %0d, want 100", mem_addr_out);
        end
        tick(1'b1, 1'b1, 1'b1, 0);
        n_tests++;
        if (mem_addr_out !== '0) begin
            n_fail++;
            $display("FAIL fs_addr: got %0d, want 0", mem_addr_out);
        end
        idle(6);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b1, 1);
    endtask

    task automatic test_reset_mid();
        refill();
        for (int i = 0; i < 5001; i++) tick(1'b1, 1'b0, 1'b1, 1);
        pix_req = 1'b0;
        resetn  = 1'b0;
        #1;
        n_tests++;
        if ({pix_valid, pix_data, frame_done, underflow} !== 11'b0 || mem_addr_out !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got vld=%b dat=%h done=%b uf=%b addr=%0d, want all 0",
                     pix_valid, pix_data, frame_done, underflow, mem_addr_out);
        end
        @(negedge clk);
        resetn  = 1'b1;
        pix_idx = 0;
        exp_uf  = 1'b0;
        idle(6);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b1, 1);
    endtask

    task automatic test_wrap();
        refill();
        n_done    = 0;
        saw_wrap  = 1'b0;
        prev_addr = mem_addr_out;
        for (int i = 0; i < FB_PIXELS + 4; i++) tick(1'b1, 1'b0, 1'b1, 1);
        n_tests++;
        if (n_done != 1) begin
            n_fail++;
            $display("FAIL frame_done_count: got %0d, want 1", n_done);
        end
        n_tests++;
        if (saw_wrap !== 1'b1) begin
            n_fail++;
            $display("FAIL addr_wrap: got %b, want 1 (76799 -> 0)", saw_wrap);
        end
    endtask

    initial begin
        resetn = 1'b0; enable = 1'b1; frame_start = 1'b0; pix_req = 1'b0;
        test_reset();
        test_underflow();
        test_steady();
        test_lane_order();
        test_back_to_back();
        test_enable();
        test_mid_frame_fs();
        test_reset_mid();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
